// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared funct3 codes, controller state encoding and default operand width
package mul_ctrl_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: request/response link between mul_ctrl and the iterative multiplier
//   req   - multiplier request (master -> slave)
//   a, b  - unsigned operand magnitudes, stable while req is high
//   ready - one-cycle product-valid strobe (slave -> master)
//   prod  - 2*XLEN unsigned product, valid with ready
interface mul_ctrl_if import mul_ctrl_pkg::*; #(parameter int XLEN = XLEN_DEF);
    logic              req;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              ready;
    logic [2*XLEN-1:0] prod;
    modport master (output req, a, b, input ready, prod);
    modport slave  (input req, a, b, output ready, prod);
endinterface

// File: rtl/mul_ctrl_sign_fix.sv
// mul_sign_fix: operand magnitude conversion and product sign restoration
//   funct3_i        - RV32M funct3 selecting operand signedness and result half
//   rs1_i, rs2_i    - raw operands
//   neg_i, prod_i   - latched negate flag and unsigned product from the multiplier
//   mag_a_o/mag_b_o - operand magnitudes (abs of 0x80..0 stays 0x80..0)
//   neg_o           - result must be negated; forced low when either operand is zero
//   hi_o            - select the high half of the product
//   prod_o          - signed-corrected product
module mul_sign_fix import mul_ctrl_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic              neg_i,
    input  logic [2*XLEN-1:0] prod_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_o,
    output logic              hi_o,
    output logic [2*XLEN-1:0] prod_o
);
    logic n1, n2;
    always_comb begin
        n1      = (funct3_i != F3_MULHU) & rs1_i[XLEN-1];
        n2      = (funct3_i == F3_MUL || funct3_i == F3_MULH) & rs2_i[XLEN-1];
        mag_a_o = n1 ? -rs1_i : rs1_i;
        mag_b_o = n2 ? -rs2_i : rs2_i;
        neg_o   = (n1 ^ n2) & (|rs1_i) & (|rs2_i);
        hi_o    = funct3_i != F3_MUL;
        prod_o  = neg_i ? -prod_i : prod_i;
    end
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: RV32M MUL/MULH/MULHSU/MULHU issue and sequencing controller
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   valid_i, flush_i       - M-op present in execute / pipeline flush
//   funct3_i, rs1_i, rs2_i - operation and operands; rd_i destination register
//   stall_o                - hold pipeline while accepting or busy
//   done_o, err_o          - one-cycle result pulse / timeout pulse (with done_o)
//   rd_o, result_o         - latched destination and final result
//   mul                    - multiplier link (master side)
// Optional MUL_CTRL_FASTPATH_EN: a zero operand skips the multiplier entirely.
module mul_ctrl import mul_ctrl_pkg::*; #(
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            err_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] result_o,
    mul_ctrl_if.master      mul
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [4:0]        rd_q, rd_d;
    logic              hi_q, hi_d, neg_q, neg_d, err_q, err_d;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg, hi, accept;
    logic [2*XLEN-1:0] prod_fix;
`ifdef MUL_CTRL_FASTPATH_EN
    logic              zero_op;
    assign zero_op = ~|rs1_i | ~|rs2_i;
`endif

    mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .neg_i    (neg_q),
        .prod_i   (mul.prod),
        .mag_a_o  (mag_a),
        .mag_b_o  (mag_b),
        .neg_o    (neg),
        .hi_o     (hi),
        .prod_o   (prod_fix)
    );

    assign accept   = valid_i & ~flush_i & ~funct3_i[2];
    assign done_o   = state_q == DONE;
    assign err_o    = done_o & err_q;
    assign rd_o     = rd_q;
    assign result_o = res_q;
    assign mul.req  = state_q == BUSY;
    assign mul.a    = a_q;
    assign mul.b    = b_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            hi_q    <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        neg_d   = neg_q;
        err_d   = err_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                stall_o = 1'b1;
                state_d = BUSY;
                cnt_d   = '0;
                a_d     = mag_a;
                b_d     = mag_b;
                rd_d    = rd_i;
                hi_d    = hi;
                neg_d   = neg;
                err_d   = 1'b0;
`ifdef MUL_CTRL_FASTPATH_EN
                if (zero_op) begin
                    state_d = DONE;
                    res_d   = '0;
                end
`endif
            end
            BUSY: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // flush beats ready, ready beats timeout on the same cycle
                if (flush_i) state_d = IDLE;
                else if (mul.ready) begin
                    res_d   = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed-vector bench for mul_ctrl with a hand-driven multiplier
module tb_mul_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        valid = 1'b0, flush = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;
    logic        stall, done, err;
    logic [4:0]  rd_out;
    logic [31:0] result;
    int          n_vec = 0, n_err = 0;

    mul_ctrl_if #(.XLEN(32)) mif ();

    mul_ctrl dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .flush_i  (flush),
        .funct3_i (f3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .rd_i     (rd),
        .stall_o  (stall),
        .done_o   (done),
        .err_o    (err),
        .rd_o     (rd_out),
        .result_o (result),
        .mul      (mif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] d);
        @(negedge clk);
        f3 = f; rs1 = r1; rs2 = r2; rd = d; valid = 1'b1;
        #1 chk("stall_accept", {63'b0, stall}, 64'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // full op: accept, check operands, return product after lat BUSY cycles
    task automatic op(input string tag, input logic [2:0] f, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [4:0] d, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] er, input int lat);
        issue(f, r1, r2, d);
        chk({tag, "_req"}, {63'b0, mif.req}, 64'd1);
        chk({tag, "_a"}, {32'b0, mif.a}, {32'b0, ea});
        chk({tag, "_b"}, {32'b0, mif.b}, {32'b0, eb});
        repeat (lat) @(negedge clk);
        mif.ready = 1'b1;
        mif.prod  = {32'b0, ea} * {32'b0, eb};
        @(negedge clk);
        mif.ready = 1'b0;
        mif.prod  = '0;
        chk({tag, "_done"}, {63'b0, done}, 64'd1);
        chk({tag, "_res"}, {32'b0, result}, {32'b0, er});
        chk({tag, "_rd"}, {59'b0, rd_out}, {59'b0, d});
        chk({tag, "_err"}, {63'b0, err}, 64'd0);
        chk({tag, "_stall_done"}, {63'b0, stall}, 64'd0);
        chk({tag, "_req_done"}, {63'b0, mif.req}, 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int n;
        mif.ready = 1'b0;
        mif.prod  = '0;
        #1;
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_req", {63'b0, mif.req}, 64'd0);
        chk("rst_res", {32'b0, result}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'd7, 32'd3, 32'hFFFF_FFEB, 2);
        op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
        op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op("mulh_m2_3", 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd7, 32'd2, 32'd3, 32'hFFFF_FFFF, 3);

`ifdef MUL_CTRL_FASTPATH_EN
        issue(3'b000, 32'd0, 32'hFFFF_FFFB, 5'd8);
        chk("fast0_done", {63'b0, done}, 64'd1);
        chk("fast0_req", {63'b0, mif.req}, 64'd0);
        chk("fast0_res", {32'b0, result}, 64'd0);
        chk("fast0_rd", {59'b0, rd_out}, 64'd8);
        issue(3'b000, 32'd9, 32'd0, 5'd9);
        chk("fast1_done", {63'b0, done}, 64'd1);
        chk("fast1_req", {63'b0, mif.req}, 64'd0);
        chk("fast1_res", {32'b0, result}, 64'd0);
        @(negedge clk);
        chk("fast1_req_after", {63'b0, mif.req}, 64'd0);
`else
        op("mul_0_m5", 3'b000, 32'd0, 32'hFFFF_FFFB, 5'd8, 32'd0, 32'd5, 32'd0, 1);
        op("mul_9_0", 3'b000, 32'd9, 32'd0, 5'd9, 32'd9, 32'd0, 32'd0, 0);
`endif

        // divide codes are never accepted
        @(negedge clk);
        f3 = 3'b100; rs1 = 32'd10; rs2 = 32'd2; valid = 1'b1;
        #1 chk("div_stall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        valid = 1'b0;
        chk("div_req", {63'b0, mif.req}, 64'd0);

        // flush in 3rd BUSY cycle together with ready
        issue(3'b000, 32'd5, 32'd6, 5'd10);
        repeat (2) @(negedge clk);
        flush = 1'b1; mif.ready = 1'b1; mif.prod = 64'd30;
        @(negedge clk);
        flush = 1'b0; mif.ready = 1'b0; mif.prod = '0;
        chk("flush_done", {63'b0, done}, 64'd0);
        chk("flush_stall", {63'b0, stall}, 64'd0);
        chk("flush_req", {63'b0, mif.req}, 64'd0);
        @(negedge clk);
        chk("flush_done2", {63'b0, done}, 64'd0);
        op("after_flush", 3'b000, 32'd5, 32'd6, 5'd11, 32'd5, 32'd6, 32'd30, 1);

        // timeout: multiplier never answers
        issue(3'b001, 32'd3, 32'd4, 5'd12);
        n = 0;
        while (!done && n < 200) begin
            if (mif.req) n++;
            @(negedge clk);
        end
        chk("to_cycles", 64'(n), 64'd64);
        chk("to_done", {63'b0, done}, 64'd1);
        chk("to_err", {63'b0, err}, 64'd1);
        chk("to_res", {32'b0, result}, 64'd0);
        @(negedge clk);
        chk("to_err_pulse", {63'b0, err}, 64'd0);

        // reset mid-BUSY
        op("pre_rst", 3'b000, 32'd2, 32'd3, 5'd13, 32'd2, 32'd3, 32'd6, 0);
        issue(3'b000, 32'd11, 32'd13, 5'd14);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {63'b0, mif.req}, 64'd0);
        chk("rst_mid_stall", {63'b0, stall}, 64'd0);
        chk("rst_mid_res", {32'b0, result}, 64'd0);
        chk("rst_mid_rd", {59'b0, rd_out}, 64'd0);
        chk("rst_mid_a", {32'b0, mif.a}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_nodone", {62'b0, done, mif.req}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
